// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: digit width,
// active-low segment patterns {a,b,c,d,e,f,g} and scan FSM states.
package seg7_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_H     = 7'b1001000;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low 7-segment decoder; values above 9 show 'H'.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_H;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_H;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Double-buffered frame, blanking gap at each slot start, registered outputs.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS  = 4,
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          load,
  input  logic [DIGIT_W*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]           dp_in,
  input  logic                          lz_blank,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [N_DIGITS-1:0]           an,
  output logic                          pending,
  output logic                          frame_done
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  scan_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [N_DIGITS-1:0][DIGIT_W-1:0]  shadow_q, shadow_d;
  logic [N_DIGITS-1:0][DIGIT_W-1:0]  pend_buf_q, pend_buf_d;
  logic [N_DIGITS-1:0]               dp_sh_q, dp_sh_d;
  logic [N_DIGITS-1:0]               dp_pend_q, dp_pend_d;
  logic                              pending_q, pending_d;
  logic                              frame_done_q, frame_done_d;
  logic [6:0]                        seg_q, seg_d;
  logic                              dp_q, dp_d;
  logic [N_DIGITS-1:0]               an_q, an_d;
  logic                              wrap_end;
  logic                              xfer;
  logic                              lz_run;
  logic [N_DIGITS-1:0]               lz_mask;
  logic [6:0]                        dec_seg;

  seg7_decoder u_dec (
    .digit (shadow_q[idx_q]),
    .seg   (dec_seg)
  );

  // Prescaler, digit index and scan phase
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wrap_end = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      if (idx_q == IDX_LAST) begin
        wrap_end = 1'b1;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_d < CNT_SHOW) ? ST_BLANK : ST_SHOW;
    end
  end

  // Pending/shadow buffers; the transfer takes the old pending data before a same-cycle load
  always_comb begin
    shadow_d   = shadow_q;
    dp_sh_d    = dp_sh_q;
    pend_buf_d = pend_buf_q;
    dp_pend_d  = dp_pend_q;
    pending_d  = pending_q;
    xfer       = pending_q && (wrap_end || !en);
    if (xfer) begin
      shadow_d  = pend_buf_q;
      dp_sh_d   = dp_pend_q;
      pending_d = 1'b0;
    end
    if (load) begin
      pend_buf_d = digits_in;
      dp_pend_d  = dp_in;
      pending_d  = 1'b1;
    end
    frame_done_d = wrap_end;
  end

  // Leading-zero mask: set for zero digits from the top down to the first nonzero, never digit 0
  always_comb begin
    lz_mask = '0;
    lz_run  = lz_blank;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run && (shadow_q[k] == '0);
      lz_mask[k] = lz_run;
    end
  end

  // Next display outputs from the current scan position
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (en && (state_q == ST_SHOW) && !lz_mask[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec_seg;
      dp_d        = ~dp_sh_q[idx_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      dp_sh_q      <= '0;
      pend_buf_q   <= '0;
      dp_pend_q    <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      dp_sh_q      <= dp_sh_d;
      pend_buf_q   <= pend_buf_d;
      dp_pend_q    <= dp_pend_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule
